// File: rtl/knn_driver.sv
// knn_driver: native-bus initiator that runs a complete KNN accelerator job
// (soft reset, test-point load, training stream, label readback) with no CPU.
// Ports: clk/rst; cmd_start/cmd_ntrain/busy/done job control;
// in_valid/in_ready/in_data point stream; res_valid/res_ready/res_data labels;
// valid/address/wdata/wstrb/rdata/ready native bus (wstrb all ones = write).
module knn_driver #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int LABEL_W     = 8,
   parameter int NT_POINTS   = 4,
   parameter int N_NEIGHBOUR = 4,
   parameter int NTRAIN_W    = 16,
   parameter int A_RESET     = 0,
   parameter int A_ENABLE    = 1,
   parameter int A_B         = 2,
   parameter int A_LABEL     = 3,
   parameter int A_A0        = 4,
   parameter int A_INFO0     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_start,
   input  logic [NTRAIN_W-1:0]   cmd_ntrain,
   output logic                  busy,
   output logic                  done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [LABEL_W-1:0]    res_data,
   output logic                  valid,
   output logic [ADDR_W-1:0]     address,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   input  logic [DATA_W-1:0]     rdata,
   input  logic                  ready
);

   localparam int NR    = NT_POINTS * N_NEIGHBOUR;
   localparam int IDX_W = (NR > 1) ? $clog2(NR) : 1;
   localparam int SW    = DATA_W / 8;

   localparam logic [IDX_W-1:0]    LAST_A = IDX_W'(NT_POINTS - 1);
   localparam logic [IDX_W-1:0]    LAST_R = IDX_W'(NR - 1);
   localparam logic [IDX_W-1:0]    ONE_I  = IDX_W'(1);
   localparam logic [NTRAIN_W-1:0] ONE_T  = NTRAIN_W'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_RST1, S_RST0, S_LOADA, S_EN,
      S_TRB, S_TRL, S_DIS, S_RD, S_FIN
   } state_t;

   state_t state, state_d;

   logic [IDX_W-1:0]    idx, idx_d;
   logic [NTRAIN_W-1:0] tcnt, tcnt_d;
   logic [NTRAIN_W-1:0] ntrain;
   logic                issue;
   logic                wr;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   data_d;
   logic                ack;
   logic                unused_rdata;

   assign ack          = valid & ready;
   assign busy         = (state != S_IDLE) && (state != S_FIN);
   assign done         = (state == S_FIN);
   assign unused_rdata = ^rdata[DATA_W-1:LABEL_W];

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // A new request is only raised while valid is low, and valid is
   // registered, so every transaction is followed by an idle cycle.
   always_comb begin
      state_d  = state;
      idx_d    = idx;
      tcnt_d   = tcnt;
      issue    = 1'b0;
      wr       = 1'b1;
      addr_d   = '0;
      data_d   = '0;
      in_ready = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_start) state_d = S_RST1;
         end
         S_RST1: begin
            addr_d = ADDR_W'(A_RESET);
            data_d = DATA_W'(1);
            issue  = ~valid;
            if (ack) state_d = S_RST0;
         end
         S_RST0: begin
            addr_d = ADDR_W'(A_RESET);
            issue  = ~valid;
            if (ack) state_d = S_LOADA;
         end
         S_LOADA: begin
            in_ready = ~valid;
            issue    = in_valid & ~valid;
            addr_d   = ADDR_W'(A_A0) + ADDR_W'(idx);
            data_d   = in_data;
            if (ack) begin
               if (idx == LAST_A) begin
                  idx_d   = '0;
                  state_d = S_EN;
               end else begin
                  idx_d = idx + ONE_I;
               end
            end
         end
         S_EN: begin
            addr_d = ADDR_W'(A_ENABLE);
            data_d = DATA_W'(1);
            issue  = ~valid;
            if (ack) state_d = (ntrain == '0) ? S_DIS : S_TRB;
         end
         S_TRB: begin
            in_ready = ~valid;
            issue    = in_valid & ~valid;
            addr_d   = ADDR_W'(A_B);
            data_d   = in_data;
            if (ack) state_d = S_TRL;
         end
         S_TRL: begin
            in_ready = ~valid;
            issue    = in_valid & ~valid;
            addr_d   = ADDR_W'(A_LABEL);
            data_d   = DATA_W'(in_data[LABEL_W-1:0]);
            if (ack) begin
               if (tcnt + ONE_T == ntrain) begin
                  tcnt_d  = '0;
                  state_d = S_DIS;
               end else begin
                  tcnt_d  = tcnt + ONE_T;
                  state_d = S_TRB;
               end
            end
         end
         S_DIS: begin
            addr_d = ADDR_W'(A_ENABLE);
            issue  = ~valid;
            if (ack) state_d = S_RD;
         end
         S_RD: begin
            // one label in flight: next read waits for the consumer
            wr     = 1'b0;
            addr_d = ADDR_W'(A_INFO0) + ADDR_W'(idx);
            issue  = ~valid & ~res_valid;
            if (res_valid & res_ready) begin
               if (idx == LAST_R) begin
                  idx_d   = '0;
                  state_d = S_FIN;
               end else begin
                  idx_d = idx + ONE_I;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         tcnt      <= '0;
         ntrain    <= '0;
         valid     <= 1'b0;
         address   <= '0;
         wdata     <= '0;
         wstrb     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         idx  <= idx_d;
         tcnt <= tcnt_d;
         if (state == S_IDLE && cmd_start) ntrain <= cmd_ntrain;
         if (ack) begin
            valid <= 1'b0;
         end else if (issue) begin
            valid   <= 1'b1;
            address <= addr_d;
            wdata   <= data_d;
            wstrb   <= {SW{wr}};
         end
         if (ack && state == S_RD) begin
            res_valid <= 1'b1;
            res_data  <= rdata[LABEL_W-1:0];
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_knn_driver.sv
// tb_knn_driver: randomized scoreboard bench for knn_driver.
// A job-level model predicts bus transactions and result labels.
module tb_knn_driver;

   localparam int NT = 4;
   localparam int NR = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_start;
   logic [15:0] cmd_ntrain;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic        valid;
   logic [4:0]  address;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   always #5 clk = ~clk;

   knn_driver dut (
      .clk(clk), .rst(rst),
      .cmd_start(cmd_start), .cmd_ntrain(cmd_ntrain),
      .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready)
   );

   typedef struct {
      int unsigned a;
      logic [31:0] d;
      bit          wr;
   } txn_t;

   txn_t        exp_bus[$];
   logic [7:0]  exp_res[$];
   logic [31:0] src_q[$];
   logic [31:0] info_mem[NR];

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;

   bit tied    = 1'b1;
   bit hold    = 1'b0;
   bit gaps    = 1'b0;
   bit bp5     = 1'b0;
   bit stall_b = 1'b0;
   int lat     = 0;

   function automatic void chk(bit ok, string name,
                               logic [63:0] act, logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, req, $time);
      end
   endfunction

   function automatic void push_w(int unsigned a, logic [31:0] d);
      txn_t t;
      t.a = a; t.d = d; t.wr = 1'b1;
      exp_bus.push_back(t);
   endfunction

   function automatic void push_r(int unsigned a);
      txn_t t;
      t.a = a; t.d = '0; t.wr = 1'b0;
      exp_bus.push_back(t);
   endfunction

   // Reference model: the whole job expressed as its list of effects.
   task automatic start_job(input int ntrain, input bit fixed);
      logic [31:0] b[$];
      int fx[8] = '{10, 11, 12, 13, 100, 1, 200, 2};
      if (fixed) begin
         foreach (fx[i]) b.push_back(32'(fx[i]));
      end else begin
         for (int i = 0; i < NT + 2 * ntrain; i++) b.push_back($urandom);
      end
      push_w(0, 1);
      push_w(0, 0);
      for (int i = 0; i < NT; i++) push_w(4 + i, b[i]);
      push_w(1, 1);
      for (int t = 0; t < ntrain; t++) begin
         push_w(2, b[NT + 2 * t]);
         push_w(3, b[NT + 2 * t + 1] & 32'hFF);
      end
      push_w(1, 0);
      for (int k = 0; k < NR; k++) begin
         push_r(8 + k);
         exp_res.push_back(info_mem[k][7:0]);
      end
      foreach (b[i]) src_q.push_back(b[i]);
      @(negedge clk);
      cmd_start  = 1'b1;
      cmd_ntrain = 16'(ntrain);
      @(negedge clk);
      cmd_start  = 1'b0;
      cmd_ntrain = 16'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n0 = done_cnt;
      int c  = 0;
      while (done_cnt == n0 && c < budget) begin
         @(negedge clk); #3;
         c++;
      end
      chk(done_cnt != n0, "done_timeout", 64'(c), 64'(budget));
      @(negedge clk); #2;
      chk(!busy && !done, "idle_after_done", 64'({busy, done}), 64'(0));
   endtask

   // bus slave
   initial begin : slave
      int wcnt = 0;
      ready = 1'b0;
      rdata = '0;
      forever begin
         @(negedge clk);
         if (stall_b && valid && address == 5'd2) begin
            ready = 1'b0;
         end else if (tied) begin
            ready = 1'b1;
         end else if (rst || !valid) begin
            ready = 1'b0;
            wcnt  = 0;
         end else if (wcnt >= lat) begin
            ready = 1'b1;
         end else begin
            ready = 1'b0;
            wcnt++;
         end
         if (valid && wstrb == 4'h0 && address >= 5'd8 && address < 5'd24)
            rdata = info_mem[address - 5'd8];
         else
            rdata = $urandom;
      end
   end

   // input stream source
   initial begin : source
      bit took = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      forever begin
         @(negedge clk);
         if (took && src_q.size() > 0) void'(src_q.pop_front());
         if (!hold && src_q.size() > 0 &&
             !(gaps && $urandom_range(2) == 0)) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
         end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end
         #2;
         took = in_valid && in_ready && !rst;
      end
   end

   // result consumer
   initial begin : consumer
      int cnt = 0;
      res_ready = 1'b0;
      forever begin
         @(negedge clk);
         cnt = res_valid ? cnt + 1 : 0;
         if (bp5) res_ready = (cnt > 5);
         else     res_ready = ($urandom_range(3) != 0);
      end
   end

   // monitor / scoreboard
   initial begin : monitor
      bit          pv    = 1'b0;
      bit          pack  = 1'b0;
      bit          prv   = 1'b0;
      bit          prr   = 1'b0;
      bit          pdone = 1'b0;
      logic [40:0] pbus  = '0;
      logic [7:0]  prd   = '0;
      txn_t        t;
      logic [7:0]  er;
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            pv = 1'b0; pack = 1'b0; prv = 1'b0; prr = 1'b0; pdone = 1'b0;
         end else begin
            if (pack)
               chk(!valid, "bus_gap", 64'(valid), 64'(0));
            else if (pv)
               chk({valid, address, wstrb, wdata[30:0]} == pbus, "bus_hold",
                   64'({valid, address, wstrb, wdata[30:0]}), 64'(pbus));
            if (valid && ready) begin
               chk(exp_bus.size() != 0, "bus_extra", 64'(address), 64'(0));
               if (exp_bus.size() != 0) begin
                  t = exp_bus.pop_front();
                  chk(address == t.a[4:0] &&
                      wstrb == (t.wr ? 4'hF : 4'h0) &&
                      (!t.wr || wdata == t.d), "bus_txn",
                      64'({address, wstrb, wdata}),
                      64'({t.a[4:0], (t.wr ? 4'hF : 4'h0), t.d}));
               end
            end
            if (prv && !prr)
               chk({res_valid, res_data} == {1'b1, prd}, "res_hold",
                   64'({res_valid, res_data}), 64'({1'b1, prd}));
            if (res_valid)
               chk(!valid, "res_no_read", 64'(valid), 64'(0));
            if (res_valid && res_ready) begin
               chk(exp_res.size() != 0, "res_extra", 64'(res_data), 64'(0));
               if (exp_res.size() != 0) begin
                  er = exp_res.pop_front();
                  chk(res_data == er, "res_data", 64'(res_data), 64'(er));
               end
            end
            if (pdone)
               chk(!done, "done_pulse", 64'(done), 64'(0));
            if (done) begin
               chk(exp_bus.size() == 0 && exp_res.size() == 0 && !busy,
                   "done_state",
                   64'({busy, 31'(exp_bus.size()), 32'(exp_res.size())}),
                   64'(0));
               done_cnt++;
            end
            pv    = valid;
            pack  = valid && ready;
            pbus  = {valid, address, wstrb, wdata[30:0]};
            prv   = res_valid;
            prr   = res_ready;
            prd   = res_data;
            pdone = done;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int c;
      rst        = 1'b1;
      cmd_start  = 1'b0;
      cmd_ntrain = '0;
      foreach (info_mem[k]) info_mem[k] = $urandom;
      repeat (3) @(negedge clk);
      #2;
      chk(busy == 0,      "rst_busy",      64'(busy),      64'(0));
      chk(done == 0,      "rst_done",      64'(done),      64'(0));
      chk(valid == 0,     "rst_valid",     64'(valid),     64'(0));
      chk(wstrb == 0,     "rst_wstrb",     64'(wstrb),     64'(0));
      chk(address == 0,   "rst_address",   64'(address),   64'(0));
      chk(wdata == 0,     "rst_wdata",     64'(wdata),     64'(0));
      chk(in_ready == 0,  "rst_in_ready",  64'(in_ready),  64'(0));
      chk(res_valid == 0, "rst_res_valid", 64'(res_valid), 64'(0));
      chk(res_data == 0,  "rst_res_data",  64'(res_data),  64'(0));
      @(negedge clk);
      rst = 1'b0;

      // basic job, ready tied high
      tied = 1'b1;
      start_job(2, 1'b1);
      wait_done(3000);

      // wait states
      tied = 1'b0;
      lat  = 3;
      foreach (info_mem[k]) info_mem[k] = $urandom;
      start_job(3, 1'b0);
      wait_done(3000);

      // result back-pressure, rdata = 0x07
      lat = 1;
      bp5 = 1'b1;
      foreach (info_mem[k]) info_mem[k] = 32'h07;
      start_job(1, 1'b0);
      wait_done(3000);
      bp5 = 1'b0;

      // zero training points
      lat = $urandom_range(2);
      foreach (info_mem[k]) info_mem[k] = $urandom;
      start_job(0, 1'b0);
      wait_done(3000);

      // input starvation, ignored start while busy
      lat  = 0;
      hold = 1'b1;
      start_job(2, 1'b0);
      c = 0;
      while (!in_ready && c < 100) begin
         @(negedge clk); #2;
         c++;
      end
      chk(in_ready, "loada_wait", 64'(c), 64'(100));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cmd_start  = (i == 4);
         cmd_ntrain = 16'd5;
         #2;
         chk(!valid && busy, "starve",
             64'({valid, busy}), 64'({1'b0, 1'b1}));
      end
      @(negedge clk);
      cmd_start = 1'b0;
      hold      = 1'b0;
      wait_done(3000);

      // reset during a stalled B write
      gaps    = 1'b1;
      lat     = 1;
      stall_b = 1'b1;
      start_job(3, 1'b0);
      c = 0;
      while (!(valid && address == 5'd2) && c < 300) begin
         @(negedge clk); #2;
         c++;
      end
      chk(valid && address == 5'd2, "b_wait", 64'(address), 64'(2));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_bus.delete();
      exp_res.delete();
      src_q.delete();
      @(negedge clk);
      rst     = 1'b0;
      stall_b = 1'b0;
      #2;
      chk(!valid && !busy && !res_valid, "mid_rst",
          64'({valid, busy, res_valid}), 64'(0));

      // fresh job after reset
      lat = 2;
      foreach (info_mem[k]) info_mem[k] = $urandom;
      start_job(4, 1'b0);
      wait_done(4000);

      chk(done_cnt == 6, "job_count", 64'(done_cnt), 64'(6));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
